// File: rtl/pipe_scoreboard.sv
// Register scoreboard for the ID stage: one countdown per architectural register
// marks in-flight writes from variable-latency producers and drives stall/bubble.
module pipe_scoreboard #(
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int MAXLAT = 8,
    parameter int LATW   = 4,
    parameter int CNTW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic            id_wr_ena,
    input  logic [AW-1:0]   id_wr_dst,
    input  logic [LATW-1:0] id_lat,
    input  logic            mem_stall,
    output logic            issue,
    output logic            stall_id,
    output logic            bubble_ex,
    output logic [NREG-1:0] busy_mask,
    output logic [CNTW-1:0] stall_cnt
);

    logic [LATW-1:0] cnt_q [NREG];
    logic [LATW-1:0] cnt_d [NREG];
    logic [CNTW-1:0] stall_cnt_q;
    logic [CNTW-1:0] stall_cnt_d;
    logic [LATW-1:0] lat_c;
    logic            raw_hz;
    logic            waw_hz;
    logic            hazard;

    function automatic logic [LATW-1:0] clamp_lat(input logic [LATW-1:0] l);
        if (32'(l) > MAXLAT) return LATW'(MAXLAT);
        return l;
    endfunction

    assign lat_c = clamp_lat(id_lat);

    // Register 0 is hard-wired zero, so its busy bit is forced low.
    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_mask[r] = (cnt_q[r] != '0);
        end
    end

    assign raw_hz = (id_rs_used && busy_mask[id_rs]) || (id_rt_used && busy_mask[id_rt]);
    // A newer write must not land before an older one still in flight to the same register.
    assign waw_hz = id_wr_ena && (id_wr_dst != '0) && (cnt_q[id_wr_dst] > lat_c);
    assign hazard = raw_hz || waw_hz;

    assign issue     = id_valid && !hazard && !mem_stall;
    assign stall_id  = id_valid && (hazard || mem_stall);
    assign bubble_ex = id_valid && hazard && !mem_stall;

    // A fresh load wins over the same-cycle decrement; mem_stall freezes everything.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!mem_stall) begin
                if (issue && id_wr_ena && (32'(id_wr_dst) == r) && (r != 0)) begin
                    cnt_d[r] = lat_c;
                end else if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_id && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
- Parametrised successor to the fixed load-use hazard unit in the 5-stage MIPS core.
- Tracks in-flight register writes with one countdown per architectural register, so variable-latency producers (loads, multi-cycle mul/div) are supported.
- Sits between the ID stage and the ID/EX register. Drives PC/IF_ID stall and ID_EX bubble insertion.
- Honours a global data-memory stall and keeps a stall performance counter.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero and never busy.
- AW, 5, register index width; must satisfy 2^AW >= NREG.
- MAXLAT, 8, largest producer latency tracked.
- LATW, 4, width of latency fields; must satisfy 2^LATW > MAXLAT.
- CNTW, 32, width of the stall performance counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID stage holds a valid instruction
- id_rs  in  AW  source register A index
- id_rt  in  AW  source register B index
- id_rs_used  in  1  instruction reads id_rs
- id_rt_used  in  1  instruction reads id_rt
- id_wr_ena  in  1  instruction writes a register
- id_wr_dst  in  AW  destination register index
- id_lat  in  LATW  number of cycles after issue that consumers must wait (0 = fully forwardable)
- mem_stall  in  1  data RAM not ready; freezes the whole pipeline
- issue  out  1  instruction leaves ID this cycle
- stall_id  out  1  hold PC and IF_ID
- bubble_ex  out  1  flush ID_EX (insert NOP)
- busy_mask  out  NREG  bit r = cnt[r] != 0
- stall_cnt  out  CNTW  cycles with stall_id = 1

Behaviour:
Clock and reset:
- Only clk is used. rst is sampled on the rising edge and is synchronous, active-high.

Reset:
- All cnt[r] = 0, so busy_mask = 0 and stall_cnt = 0.
- Reset asserted mid-operation discards all pending writes in the cycle it is sampled.

Hazard term (combinational; uses current cnt, before decrement):
- RAW: (id_rs_used & cnt[id_rs] != 0) | (id_rt_used & cnt[id_rt] != 0).
- WAW: id_wr_ena & id_wr_dst != 0 & cnt[id_wr_dst] > clamp(id_lat).
- Index 0 never hazards.

Outputs (combinational):
- issue = id_valid & ~hazard & ~mem_stall
- stall_id = id_valid & (hazard | mem_stall)
- bubble_ex = id_valid & hazard & ~mem_stall
- When mem_stall = 1, no bubble is inserted; the whole pipe freezes.
- When id_valid = 0, all three outputs are 0.

Clamp:
- clamp(id_lat) = min(id_lat, MAXLAT). Values above MAXLAT are silently clamped.

Counter update (per register r, priority order):
1. rst: cnt[r] <= 0.
2. mem_stall = 1: cnt[r] holds. No issue can occur in this case.
3. issue & id_wr_ena & id_wr_dst == r & r != 0: cnt[r] <= clamp(id_lat). The load wins over a same-cycle decrement.
4. cnt[r] != 0: cnt[r] <= cnt[r] - 1.
5. Otherwise cnt[r] holds at 0; no underflow.

Latency:
- A consumer issued N cycles after a producer with lat = L stalls for max(0, L - N + 1) cycles.
- Example: a load with L = 1 followed immediately by a dependent instruction gives exactly 1 stall cycle, which is the classic load-use case.

stall_cnt:
- Increments by 1 on each clock edge where stall_id = 1 and rst = 0.
- Saturates at all-ones; never wraps.

Self-dependency:
- An instruction that reads and writes the same register checks RAW against the old counter only.
- Its own write does not stall itself.

Test Plan:
- Reset: after rst, busy_mask = 0, stall_cnt = 0, all counters 0; id_valid = 1 with no hazard gives issue = 1.
- Load-use: issue write r3 lat = 1; next cycle id_rs = 3 used gives stall_id = 1, bubble_ex = 1 for 1 cycle, then issue = 1; stall_cnt = 1.
- Multi-cycle: issue write r5 lat = 4; dependent instruction presented the next cycle stalls exactly 4 cycles; busy_mask[5] = 1 for 4 cycles after issue.
- mem_stall freeze: r7 lat = 3 pending; mem_stall = 1 for 2 cycles gives cnt[7] held, bubble_ex = 0, stall_id = 1; dependent instruction issues 2 cycles later than in the no-stall case.
- WAW and edge cases: r9 lat = 5 pending, new write r9 lat = 1 stalls until cnt[9] <= 1; a write to r0 never sets a busy bit; id_lat = 15 clamps to MAXLAT = 8.
- Saturation and reset mid-op: CNTW = 4, hold a hazard for 20 cycles gives stall_cnt = 15; asserting rst with r2 busy clears busy_mask the next cycle.
